// File: rtl/aes_rx_packer.sv
// aes_rx_packer: packs 16 UART bytes into a 128-bit AES block, MSB-first,
// with a valid/ready handoff, overrun detection and an inter-byte timeout.
module aes_rx_packer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] plaintext,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [4:0]   byte_count,
    output logic         overrun_err,
    output logic         timeout_err
);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [0:0]    r_state;
    logic [127:0]  r_plain;
    logic [4:0]    r_count;
    logic          r_ovr;
    logic          r_to;
    logic [TW-1:0] r_tcnt;

    logic       w_store;
    logic [3:0] w_idx;
    logic       w_tick;
    logic       w_fire;

    // a byte arriving alongside a transfer becomes byte 0 of the next block
    assign w_store = rx_valid && (r_state == COLLECT || block_ready);
    assign w_idx   = r_state == HOLD ? 4'd0 : r_count[3:0];
    assign w_tick  = TIMEOUT_CYCLES != 0 && r_state == COLLECT && !rx_valid && r_count != 5'd0;
    assign w_fire  = w_tick && r_tcnt == TMAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
            r_plain <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
            r_to    <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_ovr  <= r_state == HOLD && rx_valid && !block_ready;
            r_to   <= w_fire;
            r_tcnt <= (w_tick && !w_fire) ? r_tcnt + 1'b1 : '0;
            if (w_store)
                r_plain[{~w_idx, 3'b000} +: 8] <= rx_data;
            if (r_state == COLLECT) begin
                r_count <= w_store ? r_count + 5'd1 : (w_fire ? 5'd0 : r_count);
                if (w_store && r_count == 5'd15)
                    r_state <= HOLD;
            end else if (block_ready) begin
                r_count <= rx_valid ? 5'd1 : 5'd0;
                r_state <= COLLECT;
            end
        end
    end

    assign plaintext   = r_plain;
    assign block_valid = r_state == HOLD;
    assign byte_count  = r_count;
    assign overrun_err = r_ovr;
    assign timeout_err = r_to;
endmodule

// File: tb/tb_aes_rx_packer.sv
// tb_aes_rx_packer: directed scenario tests for aes_rx_packer with a 10-cycle timeout.
module tb_aes_rx_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [127:0] plaintext;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic [4:0]   byte_count;
    logic         overrun_err;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] PAT = 128'h0123456789abcdeffedcba9876543210;

    aes_rx_packer #(.TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .plaintext(plaintext), .block_valid(block_valid), .block_ready(block_ready),
        .byte_count(byte_count), .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pat(input logic [127:0] p);
        for (int k = 0; k < 16; k++) send(p[127-8*k -: 8]);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (byte_count !== 5'd0 || block_valid !== 1'b0 || plaintext !== 128'h0 ||
            overrun_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: cnt=%0d bv=%b pt=%h ov=%b to=%b", byte_count, block_valid, plaintext, overrun_err, timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        block_ready = 1'b1;
        for (int k = 0; k < 15; k++) send(PAT[127-8*k -: 8]);
        checks++;
        if (byte_count !== 5'd15 || block_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_15: cnt=%0d bv=%b expected 15/0", byte_count, block_valid);
        end
        send(PAT[7:0]);
        checks++;
        if (block_valid !== 1'b1 || byte_count !== 5'd16 || plaintext !== PAT) begin
            errors++;
            $display("FAIL basic_block: bv=%b cnt=%0d pt=%h expected 1/16/%h", block_valid, byte_count, plaintext, PAT);
        end
        @(negedge clk);
        checks++;
        if (block_valid !== 1'b0 || byte_count !== 5'd0) begin
            errors++;
            $display("FAIL basic_release: bv=%b cnt=%0d expected 0/0", block_valid, byte_count);
        end
        block_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        send_pat(PAT);
        send(8'hAA);
        checks++;
        if (overrun_err !== 1'b1 || block_valid !== 1'b1 || plaintext !== PAT || byte_count !== 5'd16) begin
            errors++;
            $display("FAIL overrun_pulse: ov=%b bv=%b cnt=%0d pt=%h", overrun_err, block_valid, byte_count, plaintext);
        end
        @(negedge clk);
        checks++;
        if (overrun_err !== 1'b0 || plaintext !== PAT || block_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_single: ov=%b bv=%b pt=%h", overrun_err, block_valid, plaintext);
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        checks++;
        if (byte_count !== 5'd0 || block_valid !== 1'b0 || overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: cnt=%0d bv=%b ov=%b expected 0/0/0", byte_count, block_valid, overrun_err);
        end
    endtask

    task automatic test_simultaneous;
        logic [127:0] exp;
        send_pat(PAT);
        block_ready = 1'b1;
        send(8'h5A);
        block_ready = 1'b0;
        checks++;
        if (byte_count !== 5'd1 || block_valid !== 1'b0 || overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_count: cnt=%0d bv=%b ov=%b expected 1/0/0", byte_count, block_valid, overrun_err);
        end
        exp = {8'h5A, 120'h0};
        for (int k = 1; k < 16; k++) begin
            exp[127-8*k -: 8] = 8'(k * 17);
            send(8'(k * 17));
        end
        checks++;
        if (block_valid !== 1'b1 || plaintext !== exp) begin
            errors++;
            $display("FAIL simul_block: bv=%b pt=%h expected %h", block_valid, plaintext, exp);
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    task automatic test_timeout;
        for (int k = 0; k < 5; k++) send(8'(k + 1));
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (byte_count !== 5'd5 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: cnt=%0d to=%b expected 5/0", i, byte_count, timeout_err);
            end
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || byte_count !== 5'd0 || overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: to=%b cnt=%0d ov=%b expected 1/0/0", timeout_err, byte_count, overrun_err);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single: to=%b expected 0", timeout_err);
        end
        // byte arriving on the would-fire cycle wins over the timeout
        send(8'h77);
        repeat (9) @(negedge clk);
        send(8'h78);
        checks++;
        if (byte_count !== 5'd2 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_race: cnt=%0d to=%b expected 2/0", byte_count, timeout_err);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (byte_count !== 5'd0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_race_fire: cnt=%0d to=%b expected 0/1", byte_count, timeout_err);
        end
        @(negedge clk);
        send_pat(PAT);
        checks++;
        if (block_valid !== 1'b1 || plaintext !== PAT) begin
            errors++;
            $display("FAIL timeout_after: bv=%b pt=%h expected 1/%h", block_valid, plaintext, PAT);
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 8; k++) send(8'hF0 | 8'(k));
        rst = 1'b1;
        #1;
        checks++;
        if (byte_count !== 5'd0 || plaintext !== 128'h0 || block_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: cnt=%0d bv=%b pt=%h expected 0/0/0", byte_count, block_valid, plaintext);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun_err !== 1'b0 || timeout_err !== 1'b0 || byte_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_noerr: ov=%b to=%b cnt=%0d expected 0/0/0", overrun_err, timeout_err, byte_count);
        end
        send_pat(~PAT);
        checks++;
        if (block_valid !== 1'b1 || plaintext !== ~PAT) begin
            errors++;
            $display("FAIL reset_block: bv=%b pt=%h expected 1/%h", block_valid, plaintext, ~PAT);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_simultaneous;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
